bus_host_arbiter: RTL and testbench

- Round-robin arbiter that lets NrHosts request/grant bus hosts (core data ports, future DMA) share one device-side port, e.g. the upstream side of the shared bus or a single RAM data port.
- Tracks outstanding transactions in order so that each rvalid/rdata/err response is routed back to the host that issued it.
- Inserted between the hosts and the bus, with no change to the protocol: req/gnt on address phase, rvalid on response phase, in-order responses.

---
 rtl/bus_arb_pkg.sv | 31 +++
 rtl/bus_arb_id_fifo.sv | 59 +++++
 rtl/bus_host_arbiter.sv | 146 ++++++++++++++
 tb/tb_bus_host_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and the round-robin pick function for the bus host arbiter.
// Host IDs are sized for the largest legal host count so one type serves every configuration.
package bus_arb_pkg;

    localparam int unsigned MaxHosts    = 8;
    localparam int unsigned HostIdWidth = ($clog2(MaxHosts) > 0) ? $clog2(MaxHosts) : 1;

    typedef logic [HostIdWidth-1:0] host_id_t;

    typedef struct packed {
        logic     found;
        host_id_t id;
    } rr_pick_t;

    // req is zero-padded above NrHosts, so wrapping modulo MaxHosts yields
    // the same winner as wrapping modulo NrHosts.
    function automatic rr_pick_t rr_pick(input logic [MaxHosts-1:0] req, input host_id_t ptr);
        rr_pick_t res;
        host_id_t idx;
        res = '0;
        for (int i = 0; i < MaxHosts; i++) begin
            idx = ptr + host_id_t'(i);
            if (!res.found && req[idx]) begin
                res.found = 1'b1;
                res.id    = idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bus_arb_id_fifo.sv
// In-order FIFO of host IDs for transactions granted but not yet answered.
// Pushes while full and pops while empty are ignored.
module bus_arb_id_fifo
    import bus_arb_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     push,
    input  host_id_t push_id,
    input  logic     pop,
    output host_id_t head_id,
    output logic     full,
    output logic     empty
);

    localparam int unsigned PtrWidth = $clog2(Depth);

    host_id_t              mem [Depth];
    logic [PtrWidth-1:0]   wr_ptr;
    logic [PtrWidth-1:0]   rd_ptr;
    logic [PtrWidth:0]     count;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == (PtrWidth+1)'(Depth));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head_id = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= push_id;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PtrWidth'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PtrWidth'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PtrWidth+1)'(1);
                2'b01:   count <= count - (PtrWidth+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter sharing one device port among NrHosts request/grant hosts, with in-order response routing.
// Optional response timeout enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_host_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned NrHosts        = 2,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned AddressWidth   = 32,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned TimeoutCycles  = 1024
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NrHosts-1:0]                host_req_i,
    output logic [NrHosts-1:0]                host_gnt_o,
    input  logic [NrHosts*AddressWidth-1:0]   host_addr_i,
    input  logic [NrHosts-1:0]                host_we_i,
    input  logic [NrHosts*DataWidth/8-1:0]    host_be_i,
    input  logic [NrHosts*DataWidth-1:0]      host_wdata_i,
    output logic [NrHosts-1:0]                host_rvalid_o,
    output logic [DataWidth-1:0]              host_rdata_o,
    output logic                              host_err_o,
    output logic                              dev_req_o,
    input  logic                              dev_gnt_i,
    output logic [AddressWidth-1:0]           dev_addr_o,
    output logic                              dev_we_o,
    output logic [DataWidth/8-1:0]            dev_be_o,
    output logic [DataWidth-1:0]              dev_wdata_o,
    input  logic                              dev_rvalid_i,
    input  logic [DataWidth-1:0]              dev_rdata_i,
    input  logic                              dev_err_i,
    output logic                              spurious_rsp_o
);

    localparam int unsigned BeWidth = DataWidth / 8;

    if (NrHosts < 2 || NrHosts > MaxHosts) begin : g_bad_hosts
        $error("bus_host_arbiter: NrHosts must be in 2..8");
    end
    if (MaxOutstanding < 2 || (MaxOutstanding & (MaxOutstanding - 1)) != 0) begin : g_bad_depth
        $error("bus_host_arbiter: MaxOutstanding must be a power of 2, at least 2");
    end
    if (TimeoutCycles < 2) begin : g_bad_timeout
        $error("bus_host_arbiter: TimeoutCycles must be at least 2");
    end

    logic [MaxHosts-1:0] req_pad;
    rr_pick_t            pick;
    host_id_t            winner;
    host_id_t            rr_ptr;
    host_id_t            head_id;
    logic                fifo_full;
    logic                fifo_empty;
    logic                accept;
    logic                dev_rsp;
    logic                rsp_pop;
    logic                tmo_fire;
    logic                spurious_q;

    always_comb begin
        req_pad              = '0;
        req_pad[NrHosts-1:0] = host_req_i;
    end

    assign pick      = rr_pick(req_pad, rr_ptr);
    assign winner    = pick.id;
    // A full FIFO blocks the request even when a pop frees a slot this cycle.
    assign dev_req_o = pick.found & ~fifo_full;
    assign accept    = dev_req_o & dev_gnt_i;
    assign dev_rsp   = dev_rvalid_i & ~fifo_empty;
    assign rsp_pop   = dev_rsp | tmo_fire;

    always_comb begin
        dev_addr_o  = '0;
        dev_we_o    = 1'b0;
        dev_be_o    = '0;
        dev_wdata_o = '0;
        if (pick.found) begin
            dev_addr_o  = host_addr_i[int'(winner)*AddressWidth +: AddressWidth];
            dev_we_o    = host_we_i[winner];
            dev_be_o    = host_be_i[int'(winner)*BeWidth +: BeWidth];
            dev_wdata_o = host_wdata_i[int'(winner)*DataWidth +: DataWidth];
        end
    end

    always_comb begin
        host_gnt_o    = '0;
        host_rvalid_o = '0;
        for (int i = 0; i < NrHosts; i++) begin
            host_gnt_o[i]    = accept && (winner == host_id_t'(i));
            host_rvalid_o[i] = rsp_pop && (head_id == host_id_t'(i));
        end
    end

    // A synthesized timeout response carries zero data and err=1.
    assign host_rdata_o   = dev_rsp ? dev_rdata_i : '0;
    assign host_err_o     = dev_rsp ? dev_err_i : tmo_fire;
    assign spurious_rsp_o = spurious_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr     <= '0;
            spurious_q <= 1'b0;
        end else begin
            if (accept) begin
                rr_ptr <= (winner == host_id_t'(NrHosts - 1)) ? '0 : winner + host_id_t'(1);
            end
            if (dev_rvalid_i && fifo_empty) begin
                spurious_q <= 1'b1;
            end
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int unsigned TmoWidth = $clog2(TimeoutCycles) + 1;

    logic [TmoWidth-1:0] tmo_cnt;

    // Fires on the TimeoutCycles-th consecutive cycle the head waits without a response.
    assign tmo_fire = ~fifo_empty & ~dev_rvalid_i & (tmo_cnt == TmoWidth'(TimeoutCycles - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || fifo_empty || rsp_pop) begin
            tmo_cnt <= '0;
        end else if (!dev_rvalid_i) begin
            tmo_cnt <= tmo_cnt + TmoWidth'(1);
        end
    end
`else
    assign tmo_fire = 1'b0;
`endif

    bus_arb_id_fifo #(
        .Depth (MaxOutstanding)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push    (accept),
        .push_id (winner),
        .pop     (rsp_pop),
        .head_id (head_id),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_bus_host_arbiter.sv
// Self-checking bench for bus_host_arbiter: directed scenarios plus randomized traffic against a queue-based model.
// Three hosts are used so round-robin wrap-around skips a non-requesting host.
module tb_bus_host_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BW = DW / 8;
    localparam int MO = 4;
    localparam int TO = 8;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [N-1:0]      host_req_i;
    logic [N-1:0]      host_gnt_o;
    logic [N*AW-1:0]   host_addr_i;
    logic [N-1:0]      host_we_i;
    logic [N*BW-1:0]   host_be_i;
    logic [N*DW-1:0]   host_wdata_i;
    logic [N-1:0]      host_rvalid_o;
    logic [DW-1:0]     host_rdata_o;
    logic              host_err_o;
    logic              dev_req_o;
    logic              dev_gnt_i;
    logic [AW-1:0]     dev_addr_o;
    logic              dev_we_o;
    logic [BW-1:0]     dev_be_o;
    logic [DW-1:0]     dev_wdata_o;
    logic              dev_rvalid_i;
    logic [DW-1:0]     dev_rdata_i;
    logic              dev_err_i;
    logic              spurious_rsp_o;

    logic [AW-1:0] addr_a  [N];
    logic          we_a    [N];
    logic [BW-1:0] be_a    [N];
    logic [DW-1:0] wdata_a [N];

    int errors = 0;
    int checks = 0;

    // reference model state
    int m_q[$];
    int m_ptr;
    bit m_spur;
    int m_wait;

    always #5 clk_i = ~clk_i;

    always_comb begin
        host_addr_i  = '0;
        host_we_i    = '0;
        host_be_i    = '0;
        host_wdata_i = '0;
        for (int h = 0; h < N; h++) begin
            host_addr_i[h*AW +: AW]  = addr_a[h];
            host_we_i[h]             = we_a[h];
            host_be_i[h*BW +: BW]    = be_a[h];
            host_wdata_i[h*DW +: DW] = wdata_a[h];
        end
    end

    bus_host_arbiter #(
        .NrHosts        (N),
        .DataWidth      (DW),
        .AddressWidth   (AW),
        .MaxOutstanding (MO),
        .TimeoutCycles  (TO)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .host_req_i     (host_req_i),
        .host_gnt_o     (host_gnt_o),
        .host_addr_i    (host_addr_i),
        .host_we_i      (host_we_i),
        .host_be_i      (host_be_i),
        .host_wdata_i   (host_wdata_i),
        .host_rvalid_o  (host_rvalid_o),
        .host_rdata_o   (host_rdata_o),
        .host_err_o     (host_err_o),
        .dev_req_o      (dev_req_o),
        .dev_gnt_i      (dev_gnt_i),
        .dev_addr_o     (dev_addr_o),
        .dev_we_o       (dev_we_o),
        .dev_be_o       (dev_be_o),
        .dev_wdata_o    (dev_wdata_o),
        .dev_rvalid_i   (dev_rvalid_i),
        .dev_rdata_i    (dev_rdata_i),
        .dev_err_i      (dev_err_i),
        .spurious_rsp_o (spurious_rsp_o)
    );

    task automatic drive(input logic [N-1:0] req, input logic gnt, input logic rv,
                         input logic [DW-1:0] rd, input logic er);
        @(negedge clk_i);
        host_req_i   = req;
        dev_gnt_i    = gnt;
        dev_rvalid_i = rv;
        dev_rdata_i  = rd;
        dev_err_i    = er;
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        host_req_i = '0; dev_gnt_i = 1'b0; dev_rvalid_i = 1'b0; dev_rdata_i = '0; dev_err_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        m_q.delete();
        m_ptr = 0; m_spur = 0; m_wait = 0;
    endtask

    task automatic set_fixed_data();
        for (int h = 0; h < N; h++) begin
            addr_a[h]  = 32'hA000_0000 + 32'(h);
            we_a[h]    = h[0];
            be_a[h]    = BW'(h + 1);
            wdata_a[h] = 32'hD000_0000 + 32'(h);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        drive('0, 1'b0, 1'b0, '0, 1'b0);
        checks++;
        if ({dev_req_o, host_gnt_o, host_rvalid_o, host_err_o, spurious_rsp_o} !== '0)
            begin errors++; $display("FAIL reset_ctrl got %b exp 0", {dev_req_o, host_gnt_o, host_rvalid_o, host_err_o, spurious_rsp_o}); end
        checks++;
        if ({dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o, host_rdata_o} !== '0)
            begin errors++; $display("FAIL reset_data got %h exp 0", {dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o, host_rdata_o}); end
    endtask

    task automatic test_fairness();
        logic [N-1:0] eg, er;
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            drive(3'b011, 1'b1, k > 0, DW'(k), 1'b0);
            eg = '0; eg[k % 2] = 1'b1;
            er = '0; if (k > 0) er[(k - 1) % 2] = 1'b1;
            checks++;
            if (host_gnt_o !== eg) begin errors++; $display("FAIL fair_gnt[%0d] got %b exp %b", k, host_gnt_o, eg); end
            checks++;
            if (host_rvalid_o !== er) begin errors++; $display("FAIL fair_rvalid[%0d] got %b exp %b", k, host_rvalid_o, er); end
            checks++;
            if (dev_addr_o !== 32'hA000_0000 + 32'(k % 2)) begin errors++; $display("FAIL fair_addr[%0d] got %h exp %h", k, dev_addr_o, 32'hA000_0000 + 32'(k % 2)); end
        end
        drive('0, 1'b0, 1'b1, 32'h55, 1'b1);
        checks++;
        if ({host_rvalid_o, host_rdata_o, host_err_o} !== {3'b010, 32'h55, 1'b1})
            begin errors++; $display("FAIL fair_last_rsp got %b/%h/%b exp 010/55/1", host_rvalid_o, host_rdata_o, host_err_o); end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] exp_rv [3];
        exp_rv[0] = 3'b001; exp_rv[1] = 3'b010; exp_rv[2] = 3'b001;
        apply_reset();
        drive(3'b001, 1'b1, 1'b0, '0, 1'b0);
        checks++;
        if (host_gnt_o !== 3'b001) begin errors++; $display("FAIL bp_first got %b exp 001", host_gnt_o); end
        for (int k = 0; k < 3; k++) begin
            drive(3'b011, 1'b0, 1'b0, '0, 1'b0);
            checks++;
            if ({dev_req_o, host_gnt_o, dev_addr_o} !== {1'b1, 3'b000, 32'hA000_0001})
                begin errors++; $display("FAIL bp_hold[%0d] got req=%b gnt=%b addr=%h exp 1/000/a0000001", k, dev_req_o, host_gnt_o, dev_addr_o); end
        end
        drive(3'b011, 1'b1, 1'b0, '0, 1'b0);
        checks++;
        if (host_gnt_o !== 3'b010) begin errors++; $display("FAIL bp_resume got %b exp 010", host_gnt_o); end
        drive(3'b011, 1'b1, 1'b0, '0, 1'b0);
        checks++;
        if (host_gnt_o !== 3'b001) begin errors++; $display("FAIL bp_wrap got %b exp 001", host_gnt_o); end
        for (int k = 0; k < 3; k++) begin
            drive('0, 1'b0, 1'b1, DW'(k), 1'b0);
            checks++;
            if (host_rvalid_o !== exp_rv[k]) begin errors++; $display("FAIL bp_drain[%0d] got %b exp %b", k, host_rvalid_o, exp_rv[k]); end
        end
    endtask

    task automatic test_full_fifo();
        logic [N-1:0] eg;
        apply_reset();
        for (int k = 0; k < MO; k++) begin
            drive(3'b011, 1'b1, 1'b0, '0, 1'b0);
            eg = '0; eg[k % 2] = 1'b1;
            checks++;
            if (host_gnt_o !== eg) begin errors++; $display("FAIL full_fill[%0d] got %b exp %b", k, host_gnt_o, eg); end
        end
        drive(3'b011, 1'b1, 1'b0, '0, 1'b0);
        checks++;
        if ({dev_req_o, host_gnt_o} !== 4'b0000) begin errors++; $display("FAIL full_block got req=%b gnt=%b exp 0/000", dev_req_o, host_gnt_o); end
        drive(3'b011, 1'b1, 1'b1, 32'h77, 1'b0);
        checks++;
        if ({dev_req_o, host_gnt_o, host_rvalid_o} !== {1'b0, 3'b000, 3'b001})
            begin errors++; $display("FAIL full_pop got req=%b gnt=%b rv=%b exp 0/000/001", dev_req_o, host_gnt_o, host_rvalid_o); end
        drive(3'b011, 1'b1, 1'b0, '0, 1'b0);
        checks++;
        if ({dev_req_o, host_gnt_o} !== {1'b1, 3'b001}) begin errors++; $display("FAIL full_resume got req=%b gnt=%b exp 1/001", dev_req_o, host_gnt_o); end
        for (int k = 0; k < MO; k++) begin
            drive('0, 1'b0, 1'b1, '0, 1'b0);
            eg = '0; eg[(k + 1) % 2] = 1'b1;
            checks++;
            if (host_rvalid_o !== eg) begin errors++; $display("FAIL full_drain[%0d] got %b exp %b", k, host_rvalid_o, eg); end
        end
    endtask

    task automatic test_push_pop();
        apply_reset();
        drive(3'b001, 1'b1, 1'b0, '0, 1'b0);
        drive(3'b100, 1'b1, 1'b0, '0, 1'b0);
        checks++;
        if (host_gnt_o !== 3'b100) begin errors++; $display("FAIL pp_second got %b exp 100", host_gnt_o); end
        drive(3'b010, 1'b1, 1'b1, 32'h1234, 1'b0);
        checks++;
        if ({host_gnt_o, host_rvalid_o, host_rdata_o} !== {3'b010, 3'b001, 32'h1234})
            begin errors++; $display("FAIL pp_same got gnt=%b rv=%b rd=%h exp 010/001/1234", host_gnt_o, host_rvalid_o, host_rdata_o); end
        drive('0, 1'b0, 1'b1, '0, 1'b0);
        checks++;
        if (host_rvalid_o !== 3'b100) begin errors++; $display("FAIL pp_head got %b exp 100", host_rvalid_o); end
        drive('0, 1'b0, 1'b1, '0, 1'b0);
        checks++;
        if (host_rvalid_o !== 3'b010) begin errors++; $display("FAIL pp_tail got %b exp 010", host_rvalid_o); end
        drive('0, 1'b0, 1'b1, '0, 1'b0);
        checks++;
        if (host_rvalid_o !== 3'b000) begin errors++; $display("FAIL pp_empty got %b exp 000", host_rvalid_o); end
    endtask

    task automatic test_spurious_reset();
        apply_reset();
        drive('0, 1'b0, 1'b1, 32'hBEEF, 1'b1);
        checks++;
        if ({host_rvalid_o, host_rdata_o, host_err_o, spurious_rsp_o} !== '0)
            begin errors++; $display("FAIL spur_drop got rv=%b rd=%h err=%b sp=%b exp all 0", host_rvalid_o, host_rdata_o, host_err_o, spurious_rsp_o); end
        drive('0, 1'b0, 1'b0, '0, 1'b0);
        checks++;
        if (spurious_rsp_o !== 1'b1) begin errors++; $display("FAIL spur_set got %b exp 1", spurious_rsp_o); end
        drive(3'b010, 1'b1, 1'b0, '0, 1'b0);
        apply_reset();
        drive('0, 1'b0, 1'b0, '0, 1'b0);
        checks++;
        if (spurious_rsp_o !== 1'b0) begin errors++; $display("FAIL spur_clear got %b exp 0", spurious_rsp_o); end
        drive('0, 1'b0, 1'b1, 32'h1, 1'b0);
        checks++;
        if (host_rvalid_o !== 3'b000) begin errors++; $display("FAIL spur_after_rst got %b exp 000", host_rvalid_o); end
        drive('0, 1'b0, 1'b0, '0, 1'b0);
        checks++;
        if (spurious_rsp_o !== 1'b1) begin errors++; $display("FAIL spur_reset_again got %b exp 1", spurious_rsp_o); end
    endtask

`ifdef BUS_ARB_TIMEOUT_EN
    task automatic test_timeout();
        apply_reset();
        drive(3'b010, 1'b1, 1'b0, '0, 1'b0);
        for (int c = 1; c < TO; c++) begin
            drive('0, 1'b0, 1'b0, '0, 1'b0);
            checks++;
            if (host_rvalid_o !== 3'b000) begin errors++; $display("FAIL tmo_early[%0d] got %b exp 000", c, host_rvalid_o); end
        end
        drive('0, 1'b0, 1'b0, '0, 1'b0);
        checks++;
        if ({host_rvalid_o, host_err_o, host_rdata_o} !== {3'b010, 1'b1, 32'h0})
            begin errors++; $display("FAIL tmo_fire got rv=%b err=%b rd=%h exp 010/1/0", host_rvalid_o, host_err_o, host_rdata_o); end
        drive('0, 1'b0, 1'b1, '0, 1'b0);
        checks++;
        if (host_rvalid_o !== 3'b000) begin errors++; $display("FAIL tmo_empty got %b exp 000", host_rvalid_o); end
    endtask
`endif

    task automatic test_random(input int cycles);
        logic [N-1:0]  req, eg, erv;
        logic          gnt, rv, er, found, full, rsp, tmo, e_err, e_we;
        logic [DW-1:0] rd, e_rd, e_wdata;
        logic [AW-1:0] e_addr;
        logic [BW-1:0] e_be;
        int            w, h, sz;
        apply_reset();
        for (int c = 0; c < cycles; c++) begin
            for (int k = 0; k < N; k++) begin
                addr_a[k] = $urandom; we_a[k] = 1'($urandom); be_a[k] = BW'($urandom); wdata_a[k] = $urandom;
            end
            req = N'($urandom);
            gnt = ($urandom_range(0, 1) == 1);
            rv  = ($urandom_range(0, 9) < 4);
            rd  = $urandom;
            er  = 1'($urandom);
            drive(req, gnt, rv, rd, er);

            found = 1'b0; w = 0;
            for (int i = 0; i < N; i++) begin
                h = (m_ptr + i) % N;
                if (!found && req[h]) begin found = 1'b1; w = h; end
            end
            sz   = m_q.size();
            full = (sz == MO);
            rsp  = rv && (sz > 0);
`ifdef BUS_ARB_TIMEOUT_EN
            tmo  = (sz > 0) && !rv && (m_wait == TO - 1);
`else
            tmo  = 1'b0;
`endif
            eg = '0;  if (found && !full && gnt) eg[w] = 1'b1;
            erv = '0; if (rsp || tmo) erv[m_q[0]] = 1'b1;
            e_rd  = rsp ? rd : '0;
            e_err = rsp ? er : tmo;
            e_addr = found ? addr_a[w] : '0;
            e_we   = found ? we_a[w] : 1'b0;
            e_be   = found ? be_a[w] : '0;
            e_wdata = found ? wdata_a[w] : '0;

            checks++;
            if ({dev_req_o, host_gnt_o, host_rvalid_o, host_err_o, spurious_rsp_o} !== {found && !full, eg, erv, e_err, m_spur})
                begin errors++; $display("FAIL rand_ctrl[%0d] got req=%b gnt=%b rv=%b err=%b sp=%b exp %b/%b/%b/%b/%b", c,
                    dev_req_o, host_gnt_o, host_rvalid_o, host_err_o, spurious_rsp_o, found && !full, eg, erv, e_err, m_spur); end
            checks++;
            if ({dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o} !== {e_addr, e_we, e_be, e_wdata})
                begin errors++; $display("FAIL rand_mux[%0d] got %h/%b/%h/%h exp %h/%b/%h/%h", c,
                    dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o, e_addr, e_we, e_be, e_wdata); end
            checks++;
            if (host_rdata_o !== e_rd) begin errors++; $display("FAIL rand_rdata[%0d] got %h exp %h", c, host_rdata_o, e_rd); end

            if (rv && sz == 0) m_spur = 1;
            if (sz == 0 || rsp || tmo) m_wait = 0;
            else if (!rv) m_wait++;
            if (rsp || tmo) void'(m_q.pop_front());
            if (found && !full && gnt) begin
                m_q.push_back(w);
                m_ptr = (w + 1) % N;
            end
        end
    endtask

    initial begin
        rst_i = 1'b1;
        host_req_i = '0; dev_gnt_i = 1'b0; dev_rvalid_i = 1'b0; dev_rdata_i = '0; dev_err_i = 1'b0;
        for (int h = 0; h < N; h++) begin
            addr_a[h] = '0; we_a[h] = 1'b0; be_a[h] = '0; wdata_a[h] = '0;
        end
        test_reset();
        set_fixed_data();
        test_fairness();
        test_backpressure();
        test_full_fifo();
        test_push_pop();
        test_spurious_reset();
`ifdef BUS_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random(800);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
